// File: rtl/muldiv_seq.sv
// Iterative signed multiply/divide sequencer that owns the HI/LO pair.
// Optional macro MULDIV_EARLY_OUT_EN enables data-dependent early termination.
module muldiv_seq #(
    parameter int XLEN = 32,
    parameter int CNTW = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      AluControl_EX,
    input  logic            InstrVal_EX,
    input  logic [XLEN-1:0] SrcA_EX,
    input  logic [XLEN-1:0] SrcB_EX,
    input  logic            Abort,
    output logic [XLEN-1:0] Hi,
    output logic [XLEN-1:0] Lo,
    output logic            Busy,
    output logic            MdStall
);

    localparam logic [3:0] OP_MULT = 4'b1111;
    localparam logic [3:0] OP_DIV  = 4'b1110;
    localparam logic [3:0] OP_MFHI = 4'b1010;
    localparam logic [3:0] OP_MFLO = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } state_t;

    state_t             r_state;
    logic [CNTW-1:0]    r_cnt;
    logic               r_is_div;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_dbz;
    logic               r_busy;
    logic [XLEN-1:0]    r_opnd;
    logic [2*XLEN-1:0]  r_acc;
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;
`ifdef MULDIV_EARLY_OUT_EN
    logic [XLEN-1:0]    r_mpl;
`endif

    logic               w_is_mult;
    logic               w_is_div;
    logic               w_start;
    logic [XLEN-1:0]    w_abs_a;
    logic [XLEN-1:0]    w_abs_b;
    logic               w_div_zero;
    logic [XLEN:0]      w_madd;
    logic [2*XLEN-1:0]  w_mul_next;
    logic [XLEN:0]      w_rem_sh;
    logic [XLEN:0]      w_dsub;
    logic [2*XLEN-1:0]  w_div_next;
    logic [2*XLEN-1:0]  w_step;
    logic [2*XLEN-1:0]  w_prod;
    logic [2*XLEN-1:0]  w_prod_s;
    logic [XLEN-1:0]    w_quo_s;
    logic [XLEN-1:0]    w_rem_s;
    logic               w_calc_done;

    assign w_is_mult  = (AluControl_EX == OP_MULT);
    assign w_is_div   = (AluControl_EX == OP_DIV);
    // Abort in the same cycle suppresses a start.
    assign w_start    = InstrVal_EX & (w_is_mult | w_is_div) & (r_state == ST_IDLE) & ~Abort;
    assign w_abs_a    = SrcA_EX[XLEN-1] ? -SrcA_EX : SrcA_EX;
    assign w_abs_b    = SrcB_EX[XLEN-1] ? -SrcB_EX : SrcB_EX;
    assign w_div_zero = (SrcB_EX == '0);

    // Shift-add: upper half accumulates the multiplicand, lower half drains the multiplier.
    assign w_madd     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_madd, r_acc[XLEN-1:1]};

    // Restoring divide: remainder in the upper half, dividend/quotient in the lower half.
    assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_dsub     = w_rem_sh - {1'b0, r_opnd};
    assign w_div_next = w_dsub[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                     : {w_dsub[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    assign w_step     = r_is_div ? w_div_next : w_mul_next;

`ifdef MULDIV_EARLY_OUT_EN
    // Skipped iterations would only shift right, so realign by the leftover count.
    assign w_prod      = r_acc >> r_cnt;
    assign w_calc_done = (r_cnt == CNTW'(1)) | (!r_is_div && ((r_mpl >> 1) == '0));
`else
    assign w_prod      = r_acc;
    assign w_calc_done = (r_cnt == CNTW'(1));
`endif

    assign w_prod_s = (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
    assign w_quo_s  = r_dbz ? '1
                    : ((r_sign_a ^ r_sign_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0]);
    assign w_rem_s  = r_sign_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    // NOTE: all state below updates with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_dbz    <= 1'b0;
            r_busy   <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef MULDIV_EARLY_OUT_EN
            r_mpl    <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_is_div <= w_is_div;
                        r_sign_a <= SrcA_EX[XLEN-1];
                        r_sign_b <= SrcB_EX[XLEN-1];
                        r_dbz    <= w_is_div & w_div_zero;
                        r_cnt    <= CNTW'(XLEN);
                        r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
                        r_busy   <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                        r_mpl    <= w_abs_b;
`endif
                        if (w_is_div) begin
                            if (w_div_zero) begin
                                r_acc   <= {w_abs_a, {XLEN{1'b0}}};
                                r_state <= ST_FIX;
`ifdef MULDIV_EARLY_OUT_EN
                            end else if (w_abs_a < w_abs_b) begin
                                r_acc   <= {w_abs_a, {XLEN{1'b0}}};
                                r_state <= ST_FIX;
`endif
                            end else begin
                                r_acc   <= {{XLEN{1'b0}}, w_abs_a};
                                r_state <= ST_CALC;
                            end
                        end else begin
                            r_acc <= {{XLEN{1'b0}}, w_abs_b};
`ifdef MULDIV_EARLY_OUT_EN
                            r_state <= (w_abs_b == '0) ? ST_FIX : ST_CALC;
`else
                            r_state <= ST_CALC;
`endif
                        end
                    end
                end

                ST_CALC: begin
                    if (Abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt - CNTW'(1);
`ifdef MULDIV_EARLY_OUT_EN
                        r_mpl <= r_mpl >> 1;
`endif
                        if (w_calc_done) begin
                            r_state <= ST_FIX;
                        end
                    end
                end

                ST_FIX: begin
                    if (!Abort) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_s;
                            r_lo <= w_quo_s;
                        end else begin
                            r_hi <= w_prod_s[2*XLEN-1:XLEN];
                            r_lo <= w_prod_s[XLEN-1:0];
                        end
                    end
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Hi      = r_hi;
    assign Lo      = r_lo;
    assign Busy    = r_busy;
    assign MdStall = r_busy & InstrVal_EX &
                     (w_is_mult | w_is_div | (AluControl_EX == OP_MFHI) | (AluControl_EX == OP_MFLO));

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (default and MULDIV_EARLY_OUT_EN builds).
module tb_muldiv_seq;

    localparam int XLEN = 32;
    localparam logic [3:0] OP_MULT = 4'b1111;
    localparam logic [3:0] OP_DIV  = 4'b1110;
    localparam logic [3:0] OP_MFHI = 4'b1010;
    localparam logic [3:0] OP_MFLO = 4'b1011;
    localparam logic [3:0] OP_ADD  = 4'b0010;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int CYC_M7X3  = 3;
    localparam int CYC_M3X4  = 4;
    localparam int CYC_M5X3  = 3;
    localparam int CYC_D3_10 = 1;
`else
    localparam int CYC_M7X3  = 33;
    localparam int CYC_M3X4  = 33;
    localparam int CYC_M5X3  = 33;
    localparam int CYC_D3_10 = 33;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      AluControl_EX;
    logic            InstrVal_EX;
    logic [XLEN-1:0] SrcA_EX;
    logic [XLEN-1:0] SrcB_EX;
    logic            Abort;
    logic [XLEN-1:0] Hi;
    logic [XLEN-1:0] Lo;
    logic            Busy;
    logic            MdStall;

    int n_vec = 0;
    int n_err = 0;

    muldiv_seq #(.XLEN(XLEN), .CNTW(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .AluControl_EX(AluControl_EX),
        .InstrVal_EX  (InstrVal_EX),
        .SrcA_EX      (SrcA_EX),
        .SrcB_EX      (SrcB_EX),
        .Abort        (Abort),
        .Hi           (Hi),
        .Lo           (Lo),
        .Busy         (Busy),
        .MdStall      (MdStall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one MULT/DIV for a single cycle, then scrambles the operand buses.
    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        InstrVal_EX   = 1'b1;
        AluControl_EX = op;
        SrcA_EX       = a;
        SrcB_EX       = b;
        tick();
        InstrVal_EX   = 1'b0;
        AluControl_EX = OP_ADD;
        SrcA_EX       = $urandom;
        SrcB_EX       = $urandom;
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_cyc,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        start_op(op, a, b);
        cyc = 0;
        while (Busy && cyc < 200) begin
            cyc++;
            tick();
        end
        check({tag, "_busy_cycles"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_hi"}, Hi, exp_hi);
        check({tag, "_lo"}, Lo, exp_lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset         = 1'b1;
        AluControl_EX = OP_ADD;
        InstrVal_EX   = 1'b0;
        SrcA_EX       = '0;
        SrcB_EX       = '0;
        Abort         = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_hi", Hi, 32'h0);
        check("rst_lo", Lo, 32'h0);
        check("rst_busy", 32'(Busy), 32'h0);
        InstrVal_EX   = 1'b1;
        AluControl_EX = OP_MFLO;
        #1;
        check("idle_mflo_nostall", 32'(MdStall), 32'h0);
        InstrVal_EX   = 1'b0;
        AluControl_EX = OP_ADD;

        do_op("mult_7_m3", OP_MULT, 32'd7, 32'hFFFF_FFFD, CYC_M7X3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        do_op("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 33, 32'h2, 32'hFFFF_FFF2);
        do_op("div_m100_7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 33, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
        do_op("div_by_zero", OP_DIV, 32'h1234, 32'h0, 1, 32'h1234, 32'hFFFF_FFFF);
        do_op("div_neg_by_zero", OP_DIV, 32'hFFFF_0000, 32'h0, 1, 32'hFFFF_0000, 32'hFFFF_FFFF);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
        do_op("mult_minint_sq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0);
        do_op("mult_5_3", OP_MULT, 32'd5, 32'd3, CYC_M5X3, 32'h0, 32'd15);
        do_op("div_3_10", OP_DIV, 32'd3, 32'd10, CYC_D3_10, 32'd3, 32'h0);

        // Stall on a dependent MFLO held in EX right behind the MULT.
        start_op(OP_MULT, 32'd3, 32'd4);
        InstrVal_EX   = 1'b1;
        AluControl_EX = OP_MFLO;
        #1;
        cyc = 0;
        while (MdStall && cyc < 200) begin
            cyc++;
            tick();
        end
        check("stall_cycles", 32'(cyc), 32'(CYC_M3X4));
        check("stall_busy_after", 32'(Busy), 32'h0);
        check("stall_lo", Lo, 32'd12);
        check("stall_hi", Hi, 32'h0);
        InstrVal_EX   = 1'b0;
        AluControl_EX = OP_ADD;

        // Stall qualification: only MD-class valid instructions stall.
        start_op(OP_MULT, 32'd11, 32'h4000_0001);
        InstrVal_EX   = 1'b1;
        AluControl_EX = OP_ADD;
        #1;
        check("nonmd_nostall", 32'(MdStall), 32'h0);
        InstrVal_EX   = 1'b0;
        AluControl_EX = OP_MFHI;
        #1;
        check("invalid_nostall", 32'(MdStall), 32'h0);
        InstrVal_EX   = 1'b1;
        #1;
        check("mfhi_stall", 32'(MdStall), 32'h1);
        InstrVal_EX   = 1'b0;
        AluControl_EX = OP_ADD;
        cyc = 0;
        while (Busy && cyc < 200) begin
            cyc++;
            tick();
        end
        check("mult_11_hi", Hi, 32'h2);
        check("mult_11_lo", Lo, 32'hC000_000B);

        // Abort mid-CALC keeps Hi/Lo.
        do_op("div_setup", OP_DIV, 32'h5555_AAAA, 32'h0001_0000, 33, 32'h0000_AAAA, 32'h0000_5555);
        start_op(OP_MULT, 32'd7, 32'h4000_0001);
        for (int i = 0; i < 9; i++) tick();
        check("abort_pre_busy", 32'(Busy), 32'h1);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        check("abort_busy", 32'(Busy), 32'h0);
        tick();
        check("abort_hi", Hi, 32'h0000_AAAA);
        check("abort_lo", Lo, 32'h0000_5555);

        // Abort and start in the same cycle: no start.
        Abort = 1'b1;
        start_op(OP_MULT, 32'd2, 32'd2);
        Abort = 1'b0;
        check("abort_blocks_start", 32'(Busy), 32'h0);
        tick();
        check("abort_blocks_hi", Hi, 32'h0000_AAAA);
        check("abort_blocks_lo", Lo, 32'h0000_5555);

        // Reset mid-operation clears everything.
        start_op(OP_MULT, 32'd7, 32'h4000_0001);
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", 32'(Busy), 32'h0);
        check("midrst_hi", Hi, 32'h0);
        check("midrst_lo", Lo, 32'h0);

        // Abort while in FIX drops the write.
        start_op(OP_DIV, 32'd100, 32'd7);
        for (int i = 0; i < 32; i++) tick();
        check("fix_busy", 32'(Busy), 32'h1);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        check("fix_abort_busy", 32'(Busy), 32'h0);
        check("fix_abort_hi", Hi, 32'h0);
        check("fix_abort_lo", Lo, 32'h0);

        do_op("post_abort_mult", OP_MULT, 32'd5, 32'd3, CYC_M5X3, 32'h0, 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
